// File: rtl/gmii_eth_rx_stream_dec.sv
// GMII/MII receive decoder: strips preamble/SFD and emits a {cke, frm, data} byte stream.
// Optional FRAME_CNT/ERR_CNT statistics outputs are built when GMII_RX_STATS_EN is defined.
module gmii_eth_rx_stream_dec #(
  parameter int PRE_MAX = 15
) (
  input  logic        RXC,
  input  logic        RESET_N,
  input  logic [1:0]  SPEED,
  input  logic [7:0]  RXD,
  input  logic        RXDV,
  input  logic        RXER,
  output logic [9:0]  ETH_RX_STREAM,
  output logic        RX_ERR
`ifdef GMII_RX_STATS_EN
  ,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ERR_CNT
`endif
);

  localparam int            CW      = (PRE_MAX < 1) ? 1 : $clog2(PRE_MAX + 1);
  localparam logic [CW-1:0] PRE_LIM = CW'(PRE_MAX);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [7:0]    r_d;
  logic          r_dv;
  logic          r_er;
  logic [1:0]    r_state;
  logic          r_gig;
  logic [CW-1:0] r_pre_cnt;
  logic [3:0]    r_lo;
  logic          r_half;
  logic          r_err;
  logic [9:0]    r_stream;
  logic          r_rx_err;

  logic [1:0]    w_state_nx;
  logic          w_gig_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [3:0]    w_lo_nx;
  logic          w_half_nx;
  logic          w_err_nx;
  logic [9:0]    w_stream_nx;
  logic          w_rx_err_nx;
  logic          w_spd_on;
  logic          w_spd_gig;
  logic          w_gig;
  logic          w_pre;
  logic          w_sfd;

  assign w_spd_on  = (SPEED == 2'd1) || (SPEED == 2'd2);
  assign w_spd_gig = (SPEED == 2'd2);
  // Live SPEED only matters in IDLE; once a frame starts the latched copy rules.
  assign w_gig     = (r_state == S_IDLE) ? w_spd_gig : r_gig;
  assign w_pre     = w_gig ? (r_d == 8'h55) : (r_d[3:0] == 4'h5);
  assign w_sfd     = w_gig ? (r_d == 8'hD5) : (r_d[3:0] == 4'hD);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nx  = r_state;
    w_gig_nx    = r_gig;
    w_cnt_nx    = r_pre_cnt;
    w_lo_nx     = r_lo;
    w_half_nx   = r_half;
    w_err_nx    = r_err;
    w_stream_nx = 10'd0;
    w_rx_err_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx  = '0;
        w_half_nx = 1'b0;
        w_err_nx  = 1'b0;
        if (w_spd_on && r_dv) begin
          if (w_sfd) begin
            w_state_nx = S_DATA;
            w_gig_nx   = w_spd_gig;
          end else if (w_pre) begin
            w_state_nx = S_PREAMBLE;
            w_gig_nx   = w_spd_gig;
            w_cnt_nx   = CW'(1);
          end
        end
      end
      S_PREAMBLE: begin
        if (!r_dv) begin
          w_state_nx = S_IDLE;
        end else if (w_sfd) begin
          w_state_nx = S_DATA;
        end else if (w_pre && (r_pre_cnt != PRE_LIM)) begin
          w_cnt_nx = r_pre_cnt + CW'(1);
        end else begin
          w_state_nx = S_DROP;
        end
      end
      S_DATA: begin
        if (!r_dv) begin
          // End strobe; a dangling low nybble at 100M marks the frame bad.
          w_state_nx  = S_IDLE;
          w_stream_nx = 10'b10_0000_0000;
          w_rx_err_nx = r_err | (!r_gig & r_half);
        end else begin
          w_err_nx = r_err | r_er;
          if (r_gig) begin
            w_stream_nx = {2'b11, r_d};
          end else if (r_half) begin
            w_stream_nx = {2'b11, r_d[3:0], r_lo};
            w_half_nx   = 1'b0;
          end else begin
            w_lo_nx   = r_d[3:0];
            w_half_nx = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!r_dv) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge RXC or negedge RESET_N) begin
    if (!RESET_N) begin
      r_d       <= 8'd0;
      r_dv      <= 1'b0;
      r_er      <= 1'b0;
      r_state   <= S_IDLE;
      r_gig     <= 1'b0;
      r_pre_cnt <= '0;
      r_lo      <= 4'd0;
      r_half    <= 1'b0;
      r_err     <= 1'b0;
      r_stream  <= 10'd0;
      r_rx_err  <= 1'b0;
    end else begin
      r_d       <= RXD;
      r_dv      <= RXDV;
      r_er      <= RXER;
      r_state   <= w_state_nx;
      r_gig     <= w_gig_nx;
      r_pre_cnt <= w_cnt_nx;
      r_lo      <= w_lo_nx;
      r_half    <= w_half_nx;
      r_err     <= w_err_nx;
      r_stream  <= w_stream_nx;
      r_rx_err  <= w_rx_err_nx;
    end
  end

  assign ETH_RX_STREAM = r_stream;
  assign RX_ERR        = r_rx_err;

`ifdef GMII_RX_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;
  logic        w_eof;
  logic        w_to_drop;

  assign w_eof     = (r_state == S_DATA) && !r_dv;
  assign w_to_drop = (r_state != S_DROP) && (w_state_nx == S_DROP);

  always_ff @(posedge RXC or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_eof && w_rx_err_nx) || w_to_drop) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign FRAME_CNT = r_frame_cnt;
  assign ERR_CNT   = r_err_cnt;
`endif

endmodule
